// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU and MTHI/MTLO sequencer driving the HI/LO registers.
// Define MULDIV_EARLY_EN to let a multiply leave CALC as soon as its multiplier is exhausted.
module hilo_muldiv_ctrl #(
    parameter int DW    = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          op_valid,
    input  logic [2:0]    op,
    input  logic [DW-1:0] src_a,
    input  logic [DW-1:0] src_b,
    input  logic          flush,
    output logic          busy,
    output logic          stall,
    output logic          done,
    output logic          hi_we,
    output logic [DW-1:0] hi_wdata,
    output logic          lo_we,
    output logic [DW-1:0] lo_wdata
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, WB} state_t;
    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_t;

    state_t          state, state_next;
    op_t             op_q;
    logic            sign_a, sign_b;
    logic [2*DW-1:0] acc, mcand;
    logic [DW-1:0]   mplier;
    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]   hi_res, lo_res;

    logic            accept, in_mul, in_signed, is_mul, last_step, fits;
    logic [DW-1:0]   a_mag, b_mag, diff, quo, rem;
    logic [DW:0]     top;
    logic [2*DW-1:0] div_next, prod;

    assign accept    = (state == IDLE) && op_valid && !flush && (op != OP_NONE) && (op != OP_RSVD);
    assign in_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign in_signed = (op == OP_MULT) || (op == OP_DIV);
    assign a_mag     = (in_signed && src_a[DW-1]) ? -src_a : src_a;
    assign b_mag     = (in_signed && src_b[DW-1]) ? -src_b : src_b;
    assign is_mul    = (op_q == OP_MULT) || (op_q == OP_MULTU);

`ifdef MULDIV_EARLY_EN
    assign last_step = (cnt == CNT_W'(DW - 1)) || (is_mul && (mplier[DW-1:1] == '0));
`else
    assign last_step = (cnt == CNT_W'(DW - 1));
`endif

    // Restoring divide: {remainder, dividend} shifts left; the trial subtract sees the 33-bit partial remainder.
    assign top      = acc[2*DW-1:DW-1];
    assign fits     = top >= {1'b0, mplier};
    assign diff     = top[DW-1:0] - mplier;
    assign div_next = fits ? {diff, acc[DW-2:0], 1'b1} : {acc[2*DW-2:0], 1'b0};

    assign prod = (sign_a ^ sign_b) ? -acc : acc;
    assign quo  = acc[DW-1:0];
    assign rem  = acc[2*DW-1:DW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = ((op == OP_MTHI) || (op == OP_MTLO)) ? WB : CALC;
            CALC: begin
                if (flush)          state_next = IDLE;
                else if (last_step) state_next = FIX;
            end
            FIX:     state_next = flush ? IDLE : WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_NONE;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            hi_res <= '0;
            lo_res <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q   <= op_t'(op);
                    cnt    <= '0;
                    sign_a <= in_signed & src_a[DW-1];
                    sign_b <= in_signed & src_b[DW-1];
                    mcand  <= {{DW{1'b0}}, a_mag};
                    mplier <= b_mag;
                    acc    <= in_mul ? '0 : {{DW{1'b0}}, a_mag};
                    if (op == OP_MTHI) hi_res <= src_a;
                    if (op == OP_MTLO) lo_res <= src_a;
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (is_mul) begin
                        acc    <= acc + (mplier[0] ? mcand : '0);
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end else begin
                        acc <= div_next;
                    end
                end
                FIX: begin
                    if (is_mul) begin
                        hi_res <= prod[2*DW-1:DW];
                        lo_res <= prod[DW-1:0];
                    end else begin
                        // Divide by zero leaves the remainder equal to the dividend, so the normal remainder fix restores src_a.
                        lo_res <= (mplier == '0) ? '1 : ((sign_a ^ sign_b) ? -quo : quo);
                        hi_res <= sign_a ? -rem : rem;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy     = (state != IDLE);
        done     = (state == WB);
        hi_we    = (state == WB) && (op_q != OP_MTLO);
        lo_we    = (state == WB) && (op_q != OP_MTHI);
        hi_wdata = hi_res;
        lo_wdata = lo_res;
    end

    assign stall = op_valid & busy;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed corner cases plus randomized ops against an arithmetic model.
module tb_hilo_muldiv_ctrl;

    logic        clk, rst_n, op_valid, flush;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        busy, stall, done, hi_we, lo_we;
    logic [31:0] hi_wdata, lo_wdata;

    int tests  = 0;
    int failed = 0;

    hilo_muldiv_ctrl #(.DW(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .busy(busy), .stall(stall), .done(done),
        .hi_we(hi_we), .hi_wdata(hi_wdata), .lo_we(lo_we), .lo_wdata(lo_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural results from plain arithmetic; wb = cycles from acceptance edge to WB cycle.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el,
                                  output logic ehw, output logic elw, output int wb);
        logic [63:0] p;
        logic [31:0] m;
        int calc;
        calc = 32;
        eh = '0; el = '0; ehw = 1'b1; elw = 1'b1;
        p = '0; m = '0;
        case (o)
            3'd1: begin
                p = longint'($signed(a)) * longint'($signed(b));
                eh = p[63:32]; el = p[31:0];
            end
            3'd2: begin
                p = {32'b0, a} * {32'b0, b};
                eh = p[63:32]; el = p[31:0];
            end
            3'd3: begin
                if (b == 32'd0) begin el = 32'hFFFFFFFF; eh = a; end
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin el = 32'h80000000; eh = 32'd0; end
                else begin el = $signed(a) / $signed(b); eh = $signed(a) % $signed(b); end
            end
            3'd4: begin
                if (b == 32'd0) begin el = 32'hFFFFFFFF; eh = a; end
                else begin el = a / b; eh = a % b; end
            end
            3'd5: begin eh = a; elw = 1'b0; end
            default: begin el = a; ehw = 1'b0; end
        endcase
`ifdef MULDIV_EARLY_EN
        if (o == 3'd1 || o == 3'd2) begin
            m = (o == 3'd1 && b[31]) ? -b : b;
            calc = 1;
            for (int i = 0; i < 32; i++) if (m[i]) calc = i + 1;
        end
`endif
        wb = (o == 3'd5 || o == 3'd6) ? 1 : calc + 2;
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        logic ehw, elw;
        int exp_wb, n;
        bit seen;
        model(o, a, b, eh, el, ehw, elw, exp_wb);
        @(negedge clk);
        chk($sformatf("op%0d idle_before", o), busy, 1'b0);
        op = o; src_a = a; src_b = b; op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        n = 1;
        seen = 0;
        while (!seen && n <= 40) begin
            if (done) begin
                seen = 1;
                chk($sformatf("op%0d wb_cycle", o), 64'(n), 64'(exp_wb));
                chk($sformatf("op%0d hi_we", o), hi_we, ehw);
                chk($sformatf("op%0d lo_we", o), lo_we, elw);
                if (ehw) chk($sformatf("op%0d a=%h b=%h hi", o, a, b), hi_wdata, eh);
                if (elw) chk($sformatf("op%0d a=%h b=%h lo", o, a, b), lo_wdata, el);
                chk($sformatf("op%0d busy_in_wb", o), busy, 1'b1);
            end else begin
                if (!busy || hi_we || lo_we) chk($sformatf("op%0d busy_no_we n=%0d", o, n), {busy, hi_we, lo_we}, 3'b100);
            end
            @(negedge clk);
            n++;
        end
        if (!seen) chk($sformatf("op%0d done_timeout", o), 1'b0, 1'b1);
        chk($sformatf("op%0d idle_after", o), {busy, done, hi_we, lo_we}, 4'b0000);
    endtask

    function automatic logic [31:0] pick(input bit allow_min);
        int s;
        s = $urandom_range(0, 9);
        case (s)
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return allow_min ? 32'h80000000 : 32'd1;
            3, 4: return 32'($urandom_range(1, 300));
            5: return -32'($urandom_range(1, 300));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] eh, el;
        logic ehw, elw;
        int exp_wb;
        bit wr;
        logic [2:0] ro;

        rst_n = 1'b0; op_valid = 1'b0; op = 3'd0; src_a = '0; src_b = '0; flush = 1'b0;
        #12;
        chk("reset outputs", {busy, done, hi_we, lo_we}, 4'b0000);
        chk("reset hi_wdata", hi_wdata, 32'd0);
        chk("reset lo_wdata", lo_wdata, 32'd0);
        op_valid = 1'b1; op = 3'd1;
        #1;
        chk("reset stall", stall, 1'b0);
        op_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Illegal ops and flush in IDLE are not accepted
        @(negedge clk); op_valid = 1'b1; op = 3'd0;
        #1 chk("illegal0 stall", stall, 1'b0);
        @(negedge clk); chk("illegal0 busy", busy, 1'b0); op = 3'd7;
        #1 chk("illegal7 stall", stall, 1'b0);
        @(negedge clk); chk("illegal7 busy", busy, 1'b0); op = 3'd1; flush = 1'b1;
        @(negedge clk); chk("idle_flush busy", busy, 1'b0); op_valid = 1'b0; flush = 1'b0;

        run_op(3'd1, 32'hFFFFFFFF, 32'h00000002);
        run_op(3'd2, 32'hFFFFFFFF, 32'h00000002);
        run_op(3'd3, 32'hFFFFFFF9, 32'h00000002);
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
        run_op(3'd4, 32'h00000005, 32'h00000000);
        run_op(3'd3, 32'hFFFFFFFB, 32'h00000000);
        run_op(3'd1, 32'h80000000, 32'h80000000);
        run_op(3'd2, 32'h12345678, 32'h00000000);
        run_op(3'd6, 32'hCAFEF00D, 32'h0);

        // MTHI held while a MULT is in flight
        model(3'd1, 32'hFFFFFFFF, 32'h2, eh, el, ehw, elw, exp_wb);
        @(negedge clk); op = 3'd1; src_a = 32'hFFFFFFFF; src_b = 32'h2; op_valid = 1'b1;
        @(negedge clk); op = 3'd5; src_a = 32'h12345678; src_b = 32'h0;
        for (int n = 1; n <= exp_wb; n++) begin
            #1;
            if (!stall) chk($sformatf("stall held n=%0d", n), stall, 1'b1);
            if (n == exp_wb) begin
                chk("stall mult done", done, 1'b1);
                chk("stall mult hi", hi_wdata, eh);
                chk("stall mult lo", lo_wdata, el);
            end
            @(negedge clk);
        end
        chk("stall released", {busy, stall}, 2'b00);
        @(negedge clk);
        chk("mthi wb", {done, hi_we, lo_we}, 3'b110);
        chk("mthi data", hi_wdata, 32'h12345678);
        op_valid = 1'b0;
        @(negedge clk);
        chk("mthi idle", busy, 1'b0);

        // Flush a DIV at T+10
        @(negedge clk); op = 3'd3; src_a = 32'd100; src_b = 32'd7; op_valid = 1'b1;
        @(negedge clk); op_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("flush busy before", busy, 1'b1);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("flush idle", busy, 1'b0);
        wr = 0;
        repeat (40) begin
            if (hi_we || lo_we || done) wr = 1;
            @(negedge clk);
        end
        chk("flush no write", wr, 1'b0);

        // Reset a DIV at T+20
        @(negedge clk); op = 3'd3; src_a = 32'd1000; src_b = 32'd3; op_valid = 1'b1;
        @(negedge clk); op_valid = 1'b0;
        repeat (19) @(negedge clk);
        chk("rst busy before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst outputs", {busy, done, hi_we, lo_we}, 4'b0000);
        chk("rst data", {hi_wdata, lo_wdata}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        wr = 0;
        repeat (40) begin
            if (hi_we || lo_we || done || busy) wr = 1;
            @(negedge clk);
        end
        chk("rst no write", wr, 1'b0);

        for (int k = 0; k < 40; k++) begin
            ro = 3'($urandom_range(1, 6));
            run_op(ro, pick(1'b1), pick(1'b0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
